// File: rtl/lcd_init_sequencer.sv
// HD44780 4-bit power-on init, configuration commands and a 32-char two-line screen write; paces Module_LCD_Writer via its done pulse.
// Latency: issue->run 1 cycle, done->run low next edge. Stalls on iWrite_Done; cursor/blink selected by LCD_CURSOR_BLINK_EN.
module lcd_init_sequencer #(
    parameter int P_POWERUP_CYC    = 750000,
    parameter int P_WAIT_4MS_CYC   = 205000,
    parameter int P_WAIT_100US_CYC = 5000,
    parameter int P_WAIT_40US_CYC  = 2000,
    parameter int P_CLEAR_CYC      = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite_Done,
    input  logic       iRefresh,
    input  logic [7:0] iChar_Data,
    output logic [4:0] oChar_Addr,
    output logic       oWriter_Run,
    output logic [1:0] oWrite_Mode,
    output logic [3:0] oData_NIBBLE,
    output logic [7:0] oData_BYTE,
    output logic       oRS,
    output logic       oReady
);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISPLAY_ON = 8'h0F;
`else
    localparam logic [7:0] DISPLAY_ON = 8'h0C;
`endif
    localparam logic [7:0] CMD_CLEAR = 8'h01;

    // Terminal counts: a wait of N cycles ends when the counter reaches N-1.
    localparam logic [19:0] L_POWERUP = 20'(P_POWERUP_CYC - 1);
    localparam logic [19:0] L_4MS     = 20'(P_WAIT_4MS_CYC - 1);
    localparam logic [19:0] L_100US   = 20'(P_WAIT_100US_CYC - 1);
    localparam logic [19:0] L_40US    = 20'(P_WAIT_40US_CYC - 1);
    localparam logic [19:0] L_CLEAR   = 20'(P_CLEAR_CYC - 1);

    typedef enum logic [3:0] {
        S_POWERUP, S_INIT_ISSUE, S_INIT_BUSY, S_INIT_WAIT,
        S_CMD_ISSUE, S_CMD_BUSY, S_CLEAR_WAIT,
        S_ADDR_ISSUE, S_ADDR_BUSY,
        S_CHAR_FETCH, S_CHAR_CAPTURE, S_CHAR_ISSUE, S_CHAR_BUSY,
        S_IDLE
    } state_t;

    state_t      state, stateD;
    logic [19:0] delayCnt, delayCntD;
    logic [1:0]  idx, idxD;
    logic        refreshPending, refreshPendingD;
    logic [4:0]  charAddr, charAddrD;
    logic        writerRun, writerRunD;
    logic [1:0]  writeMode, writeModeD;
    logic [3:0]  dataNibble, dataNibbleD;
    logic [7:0]  dataByte, dataByteD;
    logic        rs, rsD;

    function automatic logic [3:0] initNibble(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [19:0] initLimit(input logic [1:0] i);
        case (i)
            2'd0:    return L_4MS;
            2'd1:    return L_100US;
            default: return L_40US;
        endcase
    endfunction

    function automatic logic [7:0] cmdByte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return DISPLAY_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    always_comb begin
        stateD          = state;
        delayCntD       = delayCnt;
        idxD            = idx;
        refreshPendingD = refreshPending;
        charAddrD       = charAddr;
        writerRunD      = writerRun;
        writeModeD      = writeMode;
        dataNibbleD     = dataNibble;
        dataByteD       = dataByte;
        rsD             = rs;

        if (iRefresh && state != S_IDLE)
            refreshPendingD = 1'b1;

        case (state)
            S_POWERUP: begin
                if (delayCnt >= L_POWERUP) begin
                    delayCntD = '0;
                    stateD    = S_INIT_ISSUE;
                end else begin
                    delayCntD = delayCnt + 20'd1;
                end
            end
            S_INIT_ISSUE: begin
                dataNibbleD = initNibble(idx);
                writeModeD  = 2'd0;
                rsD         = 1'b0;
                writerRunD  = 1'b1;
                stateD      = S_INIT_BUSY;
            end
            S_INIT_BUSY: begin
                if (iWrite_Done) begin
                    writerRunD = 1'b0;
                    delayCntD  = '0;
                    stateD     = S_INIT_WAIT;
                end
            end
            // Nibble writes have no settling time inside the writer, so it is timed here.
            S_INIT_WAIT: begin
                if (delayCnt >= initLimit(idx)) begin
                    delayCntD = '0;
                    if (idx == 2'd3) begin
                        idxD   = 2'd0;
                        stateD = S_CMD_ISSUE;
                    end else begin
                        idxD   = idx + 2'd1;
                        stateD = S_INIT_ISSUE;
                    end
                end else begin
                    delayCntD = delayCnt + 20'd1;
                end
            end
            S_CMD_ISSUE: begin
                dataByteD  = cmdByte(idx);
                writeModeD = 2'd1;
                rsD        = 1'b0;
                writerRunD = 1'b1;
                stateD     = S_CMD_BUSY;
            end
            S_CMD_BUSY: begin
                if (iWrite_Done) begin
                    writerRunD = 1'b0;
                    if (dataByte == CMD_CLEAR) begin
                        idxD      = 2'd0;
                        delayCntD = '0;
                        stateD    = S_CLEAR_WAIT;
                    end else begin
                        idxD   = idx + 2'd1;
                        stateD = S_CMD_ISSUE;
                    end
                end
            end
            S_CLEAR_WAIT: begin
                if (delayCnt >= L_CLEAR) begin
                    delayCntD = '0;
                    charAddrD = '0;
                    stateD    = S_ADDR_ISSUE;
                end else begin
                    delayCntD = delayCnt + 20'd1;
                end
            end
            // The line follows from the character index: 0..15 top, 16..31 bottom.
            S_ADDR_ISSUE: begin
                dataByteD  = charAddr[4] ? 8'hC0 : 8'h80;
                writeModeD = 2'd1;
                rsD        = 1'b0;
                writerRunD = 1'b1;
                stateD     = S_ADDR_BUSY;
            end
            S_ADDR_BUSY: begin
                if (iWrite_Done) begin
                    writerRunD = 1'b0;
                    stateD     = S_CHAR_FETCH;
                end
            end
            S_CHAR_FETCH: stateD = S_CHAR_CAPTURE;
            S_CHAR_CAPTURE: begin
                dataByteD = iChar_Data;
                stateD    = S_CHAR_ISSUE;
            end
            S_CHAR_ISSUE: begin
                writeModeD = 2'd1;
                rsD        = 1'b1;
                writerRunD = 1'b1;
                stateD     = S_CHAR_BUSY;
            end
            S_CHAR_BUSY: begin
                if (iWrite_Done) begin
                    writerRunD = 1'b0;
                    if (charAddr == 5'd31) begin
                        charAddrD = '0;
                        stateD    = S_IDLE;
                    end else begin
                        charAddrD = charAddr + 5'd1;
                        stateD    = (charAddr == 5'd15) ? S_ADDR_ISSUE : S_CHAR_FETCH;
                    end
                end
            end
            S_IDLE: begin
                charAddrD = '0;
                if (iRefresh || refreshPending) begin
                    refreshPendingD = 1'b0;
                    stateD          = S_ADDR_ISSUE;
                end
            end
            default: stateD = S_POWERUP;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= S_POWERUP;
            delayCnt       <= '0;
            idx            <= '0;
            refreshPending <= 1'b0;
            charAddr       <= '0;
            writerRun      <= 1'b0;
            writeMode      <= '0;
            dataNibble     <= '0;
            dataByte       <= '0;
            rs             <= 1'b0;
        end else begin
            state          <= stateD;
            delayCnt       <= delayCntD;
            idx            <= idxD;
            refreshPending <= refreshPendingD;
            charAddr       <= charAddrD;
            writerRun      <= writerRunD;
            writeMode      <= writeModeD;
            dataNibble     <= dataNibbleD;
            dataByte       <= dataByteD;
            rs             <= rsD;
        end
    end

    assign oChar_Addr   = charAddr;
    assign oWriter_Run  = writerRun;
    assign oWrite_Mode  = writeMode;
    assign oData_NIBBLE = dataNibble;
    assign oData_BYTE   = dataByte;
    assign oRS          = rs;
    assign oReady       = (state == S_IDLE);

endmodule
